enoc_credit_switch_control: RTL and testbench

//  Crossbar switch controller for an ENoC router using credit-based flow control.

---
 rtl/enoc_credit_pkg.sv | 35 +++
 rtl/enoc_rr_credit_arbiter.sv | 111 +++++++++++
 rtl/enoc_credit_switch_control.sv | 53 +++++
 tb/tb_enoc_credit_switch_control.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/enoc_credit_pkg.sv
// Shared types and the round-robin pick helper for the ENoC credit switch controller.
// Consumed by enoc_rr_credit_arbiter (lock FSM built only with ENOC_PACKET_LOCK_EN).
package enoc_credit_pkg;

  localparam int N_DEF     = 5;
  localparam int M_DEF     = 5;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF    = $clog2(DEPTH_DEF + 1);
  localparam int MAX_N     = 32;
  localparam int MAX_PW    = 5;

  typedef logic [CW_DEF-1:0] credit_t;

  typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_e;

  // First set bit of req at or above ptr, wrapping modulo n; returns one-hot (or zero).
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0]  req,
                                              input logic [MAX_PW-1:0] ptr,
                                              input int unsigned       n);
    logic [MAX_N-1:0] gnt;
    logic             found;
    int unsigned      s;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      s = (32'(ptr) + i) % n;
      if (i < n && !found && req[s[MAX_PW-1:0]]) begin
        gnt[s[MAX_PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/enoc_rr_credit_arbiter.sv
// One output port: credit counter, round-robin pointer and (ENOC_PACKET_LOCK_EN) wormhole lock.
// Grants are combinational; counter/pointer/lock advance only on ce.
module enoc_rr_credit_arbiter
  import enoc_credit_pkg::*;
#(
  parameter  int N     = 5,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_tail,
  input  logic          i_ret,
  output logic [N-1:0]  o_grant,
  output logic [CW-1:0] o_credit
);

  logic [CW-1:0]    r_credit, w_credit_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    w_k, w_k_inc;
  logic [N-1:0]     w_mask, w_elig;
  logic [MAX_N-1:0] w_pick_full;
  logic             w_any;
  logic             w_unused_pick;

  assign w_elig        = (r_credit != '0) ? (i_req & w_mask) : '0;
  assign w_pick_full   = rr_pick(MAX_N'(w_elig), MAX_PW'(r_ptr), N);
  assign w_unused_pick = ^w_pick_full;
  assign o_grant       = (ce && reset_n) ? w_pick_full[N-1:0] : '0;
  assign w_any         = |o_grant;
  assign o_credit      = r_credit;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < N; i++)
      if (o_grant[i]) w_k = PW'(i);
  end

  assign w_k_inc = (w_k == PW'(N - 1)) ? '0 : w_k + PW'(1);

  // Grant and return together cancel; a return into a full counter saturates.
  always_comb begin
    w_credit_nxt = r_credit;
    if (w_any && !i_ret)
      w_credit_nxt = r_credit - CW'(1);
    else if (!w_any && i_ret && r_credit != CW'(DEPTH))
      w_credit_nxt = r_credit + CW'(1);
  end

`ifdef ENOC_PACKET_LOCK_EN
  lock_state_e r_state, w_state_nxt;
  logic [PW-1:0] r_owner, w_owner_nxt;

  assign w_mask = (r_state == LK_LOCKED) ? (N'(1) << r_owner) : '1;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (w_any) begin
      case (r_state)
        LK_IDLE:
          if (i_tail[w_k]) w_ptr_nxt = w_k_inc;
          else begin
            w_state_nxt = LK_LOCKED;
            w_owner_nxt = w_k;
          end
        LK_LOCKED:
          if (i_tail[w_k]) begin
            w_state_nxt = LK_IDLE;
            w_ptr_nxt   = w_k_inc;
          end
        default: w_state_nxt = LK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= LK_IDLE;
      r_owner <= '0;
    end else if (ce) begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end
`else
  logic w_unused_tail;
  assign w_unused_tail = ^i_tail;
  assign w_mask        = '1;
  assign w_ptr_nxt     = w_any ? w_k_inc : r_ptr;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_credit <= CW'(DEPTH);
      r_ptr    <= '0;
    end else if (ce) begin
      r_credit <= w_credit_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  a_credit_ovf: assert property (@(posedge clk) disable iff (!reset_n)
    !(ce && i_ret && !w_any && r_credit == CW'(DEPTH)))
    else $warning("credit overflow: return with counter already full");

endmodule

// File: rtl/enoc_credit_switch_control.sv
// ENoC crossbar controller: per-output credit/round-robin arbiters, request transpose, pop ORing.
// Wormhole packet locking is enabled by defining ENOC_PACKET_LOCK_EN.
module enoc_credit_switch_control
  import enoc_credit_pkg::*;
#(
  parameter  int N     = 5,
  parameter  int M     = 5,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic [N-1:0][M-1:0]    i_output_req,
  input  logic [N-1:0]           i_tail,
  input  logic [M-1:0]           i_credit_return,
  output logic [M-1:0][N-1:0]    o_output_grant,
  output logic [N-1:0]           o_input_grant,
  output logic [M-1:0][CW-1:0]   o_credits
);

  logic [M-1:0][N-1:0] w_req_t;

  for (genvar j = 0; j < M; j++) begin : g_out
    for (genvar i = 0; i < N; i++) begin : g_tr
      assign w_req_t[j][i] = i_output_req[i][j];
    end

    enoc_rr_credit_arbiter #(.N(N), .DEPTH(DEPTH)) u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce       (ce),
      .i_req    (w_req_t[j]),
      .i_tail   (i_tail),
      .i_ret    (i_credit_return[j]),
      .o_grant  (o_output_grant[j]),
      .o_credit (o_credits[j])
    );
  end

  // Each output grants one input and each input asks for one output, so pops never collide.
  always_comb begin
    o_input_grant = '0;
    for (int j = 0; j < M; j++) o_input_grant = o_input_grant | o_output_grant[j];
  end

  for (genvar i = 0; i < N; i++) begin : g_chk
    a_req_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      !ce || $onehot0(i_output_req[i]))
      else $error("input %0d requests more than one output", i);
  end

endmodule

// File: tb/tb_enoc_credit_switch_control.sv
// Directed bench for enoc_credit_switch_control with a queue-free behavioural reference model.
module tb_enoc_credit_switch_control;

  localparam int N     = 5;
  localparam int M     = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef ENOC_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                 clk, reset_n, ce;
  logic [N-1:0][M-1:0]  req;
  logic [N-1:0]         tail;
  logic [M-1:0]         ret;
  logic [M-1:0][N-1:0]  o_output_grant;
  logic [N-1:0]         o_input_grant;
  logic [M-1:0][CW-1:0] o_credits;

  int n_tests = 0;
  int n_fail  = 0;

  enoc_credit_switch_control #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ce              (ce),
    .i_output_req    (req),
    .i_tail          (tail),
    .i_credit_return (ret),
    .o_output_grant  (o_output_grant),
    .o_input_grant   (o_input_grant),
    .o_credits       (o_credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: free slots, next-to-serve input and lock owner (-1 = free) per output.
  int m_cr[M], m_ptr[M], m_own[M];
  bit m_valid = 1'b0;

  function automatic int model_pick(int j);
    int i;
    if (!reset_n || !ce || m_cr[j] == 0) return -1;
    for (int s = 0; s < N; s++) begin
      i = (m_ptr[j] + s) % N;
      if (req[i][j] && (m_own[j] < 0 || m_own[j] == i)) return i;
    end
    return -1;
  endfunction

  initial begin : model_proc
    int g[M];
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int j = 0; j < M; j++) begin
          m_cr[j] = DEPTH; m_ptr[j] = 0; m_own[j] = -1;
        end
        m_valid = 1'b1;
      end else if (ce && m_valid) begin
        for (int j = 0; j < M; j++) g[j] = model_pick(j);
        for (int j = 0; j < M; j++) begin
          m_cr[j] = m_cr[j] - (g[j] >= 0 ? 1 : 0) + (ret[j] ? 1 : 0);
          if (m_cr[j] > DEPTH) m_cr[j] = DEPTH;
          if (g[j] >= 0) begin
            if (!LOCK) m_ptr[j] = (g[j] + 1) % N;
            else if (m_own[j] < 0) begin
              if (tail[g[j]]) m_ptr[j] = (g[j] + 1) % N;
              else            m_own[j] = g[j];
            end else if (tail[g[j]]) begin
              m_own[j] = -1;
              m_ptr[j] = (g[j] + 1) % N;
            end
          end
        end
      end
    end
  end

  initial begin : compare_proc
    logic [M-1:0][N-1:0]  e_og;
    logic [N-1:0]         e_ig;
    logic [M-1:0][CW-1:0] e_cr;
    int g;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e_ig = '0;
        for (int j = 0; j < M; j++) begin
          g       = model_pick(j);
          e_og[j] = '0;
          if (g >= 0) e_og[j][g] = 1'b1;
          e_ig    = e_ig | e_og[j];
          e_cr[j] = CW'(m_cr[j]);
        end
        check("model_out_grant", 64'(o_output_grant), 64'(e_og));
        check("model_in_grant",  64'(o_input_grant),  64'(e_ig));
        check("model_credits",   64'(o_credits),      64'(e_cr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  int ord_rr[6]  = '{0, 1, 3, 0, 1, 3};
  int ord_pkt[4];

  initial begin : stim
    logic [M-1:0][CW-1:0] all_full;
    for (int j = 0; j < M; j++) all_full[j] = CW'(DEPTH);
    if (LOCK) ord_pkt = '{2, 2, 2, 0};
    else      ord_pkt = '{2, 0, 2, 0};

    reset_n = 1'b0; ce = 1'b1; req = '0; tail = '0; ret = '0;
    req[0][0] = 1'b1;
    tick(); tick();
    #2;
    check("rst_no_grant", 64'(o_input_grant), 64'(0));
    check("rst_credits",  64'(o_credits),     64'(all_full));

    // 1) single requester drains out2
    tick();
    reset_n = 1'b1; req = '0; req[0][2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("drain_grant",  64'(o_output_grant[2]), 64'(c < 4 ? 1 : 0));
      check("drain_credit", 64'(o_credits[2]),      64'(4 - c));
      tick();
    end

    // 2) round robin 0,1,3 on out1 with a return every cycle; out2 refilled to 2
    req = '0; req[0][1] = 1'b1; req[1][1] = 1'b1; req[3][1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ret = '0; ret[1] = 1'b1; ret[2] = (c < 2);
      #2;
      check("rr_order",  64'(o_output_grant[1]), 64'(oh(ord_rr[c])));
      check("rr_credit", 64'(o_credits[1]),      64'(4));
      tick();
    end

    // 3) grant+return cancels; return at full saturates
    req = '0; req[0][2] = 1'b1; ret = '0; ret[2] = 1'b1;
    #2;
    check("gr_ret_grant", 64'(o_output_grant[2]), 64'(1));
    check("gr_ret_pre",   64'(o_credits[2]),      64'(2));
    tick();
    req = '0;
    #2; check("gr_ret_same", 64'(o_credits[2]), 64'(2)); tick();
    #2; check("ret_inc3",    64'(o_credits[2]), 64'(3)); tick();
    #2; check("ret_full",    64'(o_credits[2]), 64'(4)); tick();
    ret = '0;
    #2; check("ret_sat",     64'(o_credits[2]), 64'(4)); tick();

    // 4) ce low: no grants, nothing moves
    ce = 1'b0; req = '0; req[0][1] = 1'b1; req[1][1] = 1'b1; req[3][0] = 1'b1; ret[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("ce_no_grant", 64'(o_input_grant), 64'(0));
      check("ce_credits",  64'({o_credits[1], o_credits[0]}), 64'({3'd4, 3'd4}));
      tick();
    end
    ce = 1'b1; ret = '0; req[3] = '0;
    #2; check("ce_ptr_held", 64'(o_output_grant[1]), 64'(1)); tick();

    // 5) three-flit packet from in2 to out0 competing with in0
    req = '0; req[2][0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) req[0][0] = 1'b1;
      if (c == 3) req[2] = '0;
      tail = '0; tail[2] = (c == 2);
      #2;
      check("pkt_order",  64'(o_output_grant[0]), 64'(oh(ord_pkt[c])));
      check("pkt_credit", 64'(o_credits[0]),      64'(4 - c));
      tick();
    end

    // 6) reset mid-packet on out3 with one credit left
    req = '0; tail = '0; req[2][3] = 1'b1;
    tick(); tick(); tick();
    #2; check("mid_credit", 64'(o_credits[3]), 64'(1));
    reset_n = 1'b0; req[0][3] = 1'b1; req[4][3] = 1'b1;
    #1; check("mid_rst_no_grant", 64'(o_input_grant), 64'(0));
    tick();
    reset_n = 1'b1;
    #2;
    check("post_rst_credits", 64'(o_credits), 64'(all_full));
    check("post_rst_winner",  64'(o_output_grant[3]), 64'(1));
    tick();
    req = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
